// File: rtl/wb_pkg.sv
// Wishbone B3 constants and burst address helper shared by the memory slave
// and the bus masters that talk to it.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2,
    ST_ERR  = 2'd3
  } wb_state_e;

  // Word index of the next beat. Linear wraps only by caller truncation;
  // wrap modes keep the upper bits and roll the low 2/3/4 bits.
  function automatic logic [31:0] next_beat_idx(input logic [31:0] idx,
                                                input logic [1:0]  bte);
    logic [31:0] inc;
    inc = idx + 32'd1;
    case (bte)
      BTE_WRAP4:  next_beat_idx = {idx[31:2], inc[1:0]};
      BTE_WRAP8:  next_beat_idx = {idx[31:3], inc[2:0]};
      BTE_WRAP16: next_beat_idx = {idx[31:4], inc[3:0]};
      default:    next_beat_idx = inc;
    endcase
  endfunction

endpackage

// File: rtl/wb_emu_ram.sv
// Single-port byte-enable synchronous RAM, read-first, contents never reset.
module wb_emu_ram #(
  parameter int    DW        = 32,
  parameter int    DEPTH     = 4096,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [DW/8-1:0]          be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata_q
);

  logic [DW-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= mem[addr];
  end

endmodule

// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 memory slave: classic and registered-feedback bursts, all BTE
// wrap modes, byte lanes, programmable first-beat wait states, range errors.
module wb_burst_mem_slave
  import wb_pkg::*;
#(
  parameter int             DW          = 32,
  parameter int             AW          = 32,
  parameter int             DEPTH       = 4096,
  parameter logic [AW-1:0]  BASE_ADDR   = '0,
  parameter int             WAIT_STATES = 0,
  parameter string          INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_cyc_o,
  input  logic            wb_stb_o,
  input  logic            wb_we_o,
  input  logic [AW-1:0]   wb_adr_o,
  input  logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_o,
  input  logic [2:0]      wb_cti_o,
  input  logic [1:0]      wb_bte_o,
  output logic [DW-1:0]   wb_dat_i,
  output logic            wb_ack_i,
  output logic            wb_err_i,
  output logic            wb_rty_i,
  output logic [1:0]      clmode
);

  localparam int SW     = DW / 8;
  localparam int BYTE_W = $clog2(SW);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int OFF_W  = IDX_W + BYTE_W;

  wb_state_e        state_q, state_d;
  logic [IDX_W-1:0] beat_q, beat_d;
  logic [3:0]       wait_q, wait_d;
  logic             vld_q, vld_d;

  logic             req, in_range, ack, err, ram_we;
  logic [IDX_W-1:0] adr_idx, beat_nxt, ram_addr;
  logic [DW-1:0]    ram_rdata;
  logic             unused_adr_lsb;

  assign req      = wb_cyc_o & wb_stb_o;
  // BASE_ADDR is aligned to the memory size, so the range check is a
  // compare of the bits above the offset and never overflows AW.
  assign in_range = (wb_adr_o[AW-1:OFF_W] == BASE_ADDR[AW-1:OFF_W]);
  assign adr_idx  = wb_adr_o[OFF_W-1:BYTE_W];
  assign beat_nxt = IDX_W'(next_beat_idx(32'(beat_q), wb_bte_o));
  assign unused_adr_lsb = ^wb_adr_o[BYTE_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      vld_q   <= vld_d;
    end
  end

  // vld_q says the RAM output register holds the word at beat_q; a write
  // beat occupies the single port, so a read directly after it waits a cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    vld_d   = !ram_we;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (!in_range) begin
            state_d = ST_ERR;
          end else begin
            beat_d = adr_idx;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              wait_d  = 4'(WAIT_STATES - 1);
            end else begin
              state_d = ST_XFER;
            end
          end
        end
      end
      ST_WAIT: begin
        if (!wb_cyc_o)           state_d = ST_IDLE;
        else if (wait_q == 4'd0) state_d = ST_XFER;
        else                     wait_d  = wait_q - 4'd1;
      end
      ST_XFER: begin
        if (!wb_cyc_o) begin
          state_d = ST_IDLE;
        end else if (ack) begin
          beat_d = beat_nxt;
          if (wb_cti_o != CTI_INCR) state_d = ST_IDLE;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack      = 1'b0;
    err      = 1'b0;
    ram_we   = 1'b0;
    ram_addr = beat_q;
    case (state_q)
      ST_IDLE: ram_addr = adr_idx;
      ST_XFER: begin
        ack    = req & (wb_we_o | vld_q);
        ram_we = ack & wb_we_o;
        // Read beat: prefetch the following word so the next ACK is bubble-free.
        if (ack && !wb_we_o) ram_addr = beat_nxt;
      end
      ST_ERR:  err = wb_cyc_o;
      default: ;
    endcase
  end

  wb_emu_ram #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .be      (wb_sel_o),
    .addr    (ram_addr),
    .wdata   (wb_dat_o),
    .rdata_q (ram_rdata)
  );

  assign wb_ack_i = ack;
  assign wb_err_i = err;
  assign wb_dat_i = (ack && !wb_we_o) ? ram_rdata : '0;
  assign wb_rty_i = 1'b0;
  assign clmode   = 2'b00;

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed bench: two slaves (0 and 3 wait states) driven by a burst task,
// read data checked against a model memory through an expectation queue.
module tb_wb_burst_mem_slave;
  import wb_pkg::*;

  localparam int DEPTH = 256;

  logic        clk, rst;
  logic        cyc [2], stb [2], we [2];
  logic [31:0] adr [2], wdat [2], rdat [2];
  logic [3:0]  sel [2];
  logic [2:0]  cti [2];
  logic [1:0]  bte [2], clm [2];
  logic        ack [2], err [2], rty [2];

  logic [31:0] mdl [2][DEPTH];
  logic [31:0] exp_q [$];
  int          n_cmp = 0, n_err = 0;
  int          fl, tot;
  logic [31:0] last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_burst_mem_slave #(.DW(32), .AW(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0),
                       .WAIT_STATES(0), .INIT_FILE("")) u_ws0 (
    .clk(clk), .rst(rst), .wb_cyc_o(cyc[0]), .wb_stb_o(stb[0]), .wb_we_o(we[0]),
    .wb_adr_o(adr[0]), .wb_sel_o(sel[0]), .wb_dat_o(wdat[0]), .wb_cti_o(cti[0]),
    .wb_bte_o(bte[0]), .wb_dat_i(rdat[0]), .wb_ack_i(ack[0]), .wb_err_i(err[0]),
    .wb_rty_i(rty[0]), .clmode(clm[0]));

  wb_burst_mem_slave #(.DW(32), .AW(32), .DEPTH(DEPTH), .BASE_ADDR(32'h0),
                       .WAIT_STATES(3), .INIT_FILE("")) u_ws3 (
    .clk(clk), .rst(rst), .wb_cyc_o(cyc[1]), .wb_stb_o(stb[1]), .wb_we_o(we[1]),
    .wb_adr_o(adr[1]), .wb_sel_o(sel[1]), .wb_dat_o(wdat[1]), .wb_cti_o(cti[1]),
    .wb_bte_o(bte[1]), .wb_dat_i(rdat[1]), .wb_ack_i(ack[1]), .wb_err_i(err[1]),
    .wb_rty_i(rty[1]), .clmode(clm[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nxt(input int w, input logic [1:0] b);
    int len;
    case (b)
      2'b00:   return (w + 1) % DEPTH;
      2'b01:   len = 4;
      2'b10:   len = 8;
      default: len = 16;
    endcase
    return (w / len) * len + (w + 1) % len;
  endfunction

  // Runs one cycle/burst of n beats. Later beats drive a bogus address that
  // the slave must ignore. Latency/total are counted in rising edges from
  // the first assertion of cyc&stb.
  task automatic burst(input int d, input bit wr, input logic [31:0] badr, input int n,
                       input logic [1:0] bt, input logic [3:0] be, input logic [31:0] dbase,
                       input int stall_after, input int stall_len, input int abort_beat,
                       output int first_lat, output int total, output logic [31:0] last_rd);
    int idx, b, edges, guard;
    logic [31:0] wd;
    idx = int'((badr >> 2) % DEPTH);
    b = 0; edges = 0; first_lat = -1; total = 0; last_rd = '0;
    @(posedge clk); #1;
    while (b < n) begin
      wd = dbase + 32'(b);
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr; sel[d] = be; wdat[d] = wd; bte[d] = bt;
      adr[d] = (b == 0) ? badr : 32'hFFFF_FFF0;
      cti[d] = (n == 1) ? CTI_CLASSIC : ((b == n - 1) ? CTI_EOB : CTI_INCR);
      if (!wr) exp_q.push_back(mdl[d][idx]);
      @(negedge clk);
      if (b == abort_beat) begin
        rst = 1'b0; #1;
        chk("abort_ack", 32'(ack[d]), 32'd0);
        chk("abort_dat", rdat[d], 32'd0);
        @(posedge clk); #1;
        cyc[d] = 1'b0; stb[d] = 1'b0; rst = 1'b1;
        total = edges;
        return;
      end
      guard = 0;
      while (!ack[d] && guard < 40) begin
        @(posedge clk); edges++;
        @(negedge clk); guard++;
      end
      if (!ack[d]) begin
        chk("ack_timeout", 32'(ack[d]), 32'd1);
        @(posedge clk); #1;
        cyc[d] = 1'b0; stb[d] = 1'b0;
        total = edges;
        return;
      end
      if (first_lat < 0) first_lat = edges;
      chk("err_with_ack", 32'(err[d]), 32'd0);
      if (!wr) begin
        last_rd = rdat[d];
        chk("rdata", rdat[d], exp_q.pop_front());
      end else begin
        for (int i = 0; i < 4; i++) if (be[i]) mdl[d][idx][8*i +: 8] = wd[8*i +: 8];
      end
      idx = nxt(idx, bt);
      b++;
      @(posedge clk); edges++; #1;
      if (b == stall_after && b < n) begin
        stb[d] = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_noack", 32'(ack[d]), 32'd0);
          @(posedge clk); edges++; #1;
        end
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    total = edges;
    @(negedge clk);
    chk("idle_ack", 32'(ack[d]), 32'd0);
    chk("idle_err", 32'(err[d]), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = '0; sel[d] = '0;
      wdat[d] = '0; cti[d] = '0; bte[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ack", 32'(ack[d]), 32'd0);
      chk("rst_err", 32'(err[d]), 32'd0);
      chk("rst_dat", rdat[d], 32'd0);
      chk("rst_rty", 32'(rty[d]), 32'd0);
      chk("rst_clmode", 32'(clm[d]), 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;

    // Fill words 0..31, then the classic-test words.
    burst(0, 1, 32'h0, 32, BTE_LINEAR, 4'hF, 32'hC0DE_0000, -1, 0, -1, fl, tot, last);
    chk("fill_lat", fl, 1);
    chk("fill_total", tot, 33);
    burst(0, 1, 32'h40, 1, BTE_LINEAR, 4'hF, 32'hDEAD_BEEF, -1, 0, -1, fl, tot, last);
    burst(0, 1, 32'h80, 1, BTE_LINEAR, 4'hF, 32'hAAAA_AAAA, -1, 0, -1, fl, tot, last);

    // Classic read, then a misaligned one that must hit the same word.
    burst(0, 0, 32'h40, 1, BTE_LINEAR, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("classic_lat", fl, 1);
    chk("classic_dat", last, 32'hDEAD_BEEF);
    burst(0, 0, 32'h43, 1, BTE_LINEAR, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("misalign_dat", last, 32'hDEAD_BEEF);

    // Wrap bursts: 6,7,0..5 / 19,16,17,18 / 5..15,0..4.
    burst(0, 0, 32'h18, 8, BTE_WRAP8, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("wrap8_total", tot, 9);
    chk("wrap8_last", last, 32'hC0DE_0005);
    burst(0, 0, 32'h4C, 4, BTE_WRAP4, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("wrap4_last", last, 32'hC0DE_0012);
    burst(0, 0, 32'h14, 16, BTE_WRAP16, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("wrap16_total", tot, 17);

    // Byte-lane write.
    burst(0, 1, 32'h80, 1, BTE_LINEAR, 4'b0101, 32'h1122_3344, -1, 0, -1, fl, tot, last);
    burst(0, 0, 32'h80, 1, BTE_LINEAR, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("bytelane_dat", last, 32'hAA22_AA44);

    // Out of range: one ERR cycle, no ACK, memory untouched.
    @(posedge clk); #1;
    cyc[0] = 1; stb[0] = 1; we[0] = 1; adr[0] = 32'(DEPTH * 4); sel[0] = 4'hF;
    wdat[0] = 32'h1234_5678; cti[0] = CTI_CLASSIC;
    @(negedge clk);
    chk("oor_err_early", 32'(err[0]), 32'd0);
    @(negedge clk);
    chk("oor_err", 32'(err[0]), 32'd1);
    chk("oor_ack", 32'(ack[0]), 32'd0);
    @(posedge clk); #1;
    cyc[0] = 0; stb[0] = 0;
    @(negedge clk);
    chk("oor_err_once", 32'(err[0]), 32'd0);
    burst(0, 0, 32'h0, 1, BTE_LINEAR, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("oor_mem", last, 32'hC0DE_0000);

    // Linear burst across the top of memory wraps to word 0.
    burst(0, 1, 32'(254 * 4), 4, BTE_LINEAR, 4'hF, 32'h7070_0000, -1, 0, -1, fl, tot, last);
    burst(0, 0, 32'(254 * 4), 4, BTE_LINEAR, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("topwrap_last", last, 32'h7070_0003);

    // Reset during beat 3 of an 8-beat write.
    burst(0, 1, 32'h100, 8, BTE_LINEAR, 4'hF, 32'h5A5A_0000, -1, 0, -1, fl, tot, last);
    burst(0, 1, 32'h100, 8, BTE_LINEAR, 4'hF, 32'h0BAD_0000, -1, 0, 3, fl, tot, last);
    for (int w = 64; w < 72; w++)
      burst(0, 0, 32'(w * 4), 1, BTE_LINEAR, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("abort_unwritten", last, 32'h5A5A_0007);
    burst(0, 0, 32'h108, 1, BTE_LINEAR, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
    chk("abort_written", last, 32'h0BAD_0002);

    // Three wait states, master stall after beat 2.
    burst(1, 1, 32'h140, 4, BTE_LINEAR, 4'hF, 32'h3C3C_0000, 2, 2, -1, fl, tot, last);
    chk("ws3_wr_lat", fl, 4);
    chk("ws3_wr_total", tot, 10);
    for (int w = 80; w < 84; w++) begin
      burst(1, 0, 32'(w * 4), 1, BTE_LINEAR, 4'hF, 32'h0, -1, 0, -1, fl, tot, last);
      chk("ws3_rd_lat", fl, 4);
    end
    chk("ws3_rd_last", last, 32'h3C3C_0003);
    burst(1, 0, 32'h140, 4, BTE_LINEAR, 4'hF, 32'h0, 1, 3, -1, fl, tot, last);
    chk("ws3_rdburst_total", tot, 11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
